// File: rtl/bsg_wormhole_router_input_control_vc_pkg.sv
// Shared definitions for the multi-VC wormhole router input controller.
//
// Holds the default configuration, the payload-length type and the widths
// needed to name a virtual channel or an output direction by index.

package bsg_wormhole_router_input_control_vc_pkg;

    // Default configuration of the router input port.
    localparam int num_vc_lp           = 2;
    localparam int output_dirs_lp      = 5;
    localparam int payload_len_bits_lp = 4;
    localparam int hold_reqs_lp        = 1;

    // Width of an index over n items; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int vc_id_width_lp  = id_width(num_vc_lp);
    localparam int dir_id_width_lp = id_width(output_dirs_lp);

    // Header payload length: number of body flits that follow the header.
    typedef logic [payload_len_bits_lp-1:0] bsg_wormhole_len_t;

endpackage

// File: rtl/bsg_wormhole_router_input_control_vc_chan.sv
// Control for one virtual channel of a wormhole router input port.
//
// Tracks the head flit of one VC's input FIFO. The VC is idle while the
// payload counter is zero; the head flit is then a header. A header dequeue
// loads the counter with the payload length and latches the destination;
// each body dequeue decrements the counter until it returns to zero.
//
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   v              head flit valid
//   dest           one-hot destination (headers only)
//   len            payload length (headers only)
//   yumi           dequeue of the head flit
//   reqs           output-direction request
//   detected_header head flit is a valid header
//   release_flit   head flit is valid and is the last flit of its packet
//   busy           VC is inside a packet body
//   protocol_err   sticky protocol-error flag

module bsg_wormhole_router_input_control_vc_chan
    import bsg_wormhole_router_input_control_vc_pkg::*;
#(
    parameter int dirs_p      = output_dirs_lp,
    parameter int len_bits_p  = payload_len_bits_lp,
    parameter bit hold_reqs_p = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  v,
    input  logic [dirs_p-1:0]     dest,
    input  logic [len_bits_p-1:0] len,
    input  logic                  yumi,
    output logic [dirs_p-1:0]     reqs,
    output logic                  detected_header,
    output logic                  release_flit,
    output logic                  busy,
    output logic                  protocol_err
);

    logic [len_bits_p-1:0] ctr_r;
    logic [dirs_p-1:0]     dest_r;
    logic                  err_r;

    logic idle;
    logic last_body;
    logic take;
    logic load;
    logic dec;
    logic bad_yumi;
    logic bad_dest;

    assign idle      = (ctr_r == '0);
    assign last_body = (ctr_r == len_bits_p'(1));

    // A dequeue only moves the counter when it pops a real flit; a yumi
    // without valid is flagged but otherwise ignored.
    assign take     = yumi & v;
    assign load     = take & idle;
    assign dec      = take & ~idle;
    assign bad_yumi = yumi & ~v;
    assign bad_dest = load & ~$onehot(dest);

    // Set/down counter: load wins over decrement. Decrement is only enabled
    // while nonzero, so the counter cannot wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctr_r  <= '0;
            dest_r <= '0;
            err_r  <= 1'b0;
        end else begin
            if (load) begin
                ctr_r  <= len;
                dest_r <= dest;
            end else if (dec) begin
                ctr_r <= ctr_r - len_bits_p'(1);
            end
            if (bad_yumi | bad_dest) begin
                err_r <= 1'b1;
            end
        end
    end

    // Outputs are combinational; everything except the error flag is
    // forced low while reset is held.
    always_comb begin
        reqs            = '0;
        detected_header = 1'b0;
        release_flit    = 1'b0;
        busy            = 1'b0;
        if (!reset) begin
            busy = ~idle;
            if (idle) begin
                detected_header = v;
                reqs            = v ? dest : '0;
                release_flit    = v & (len == '0);
            end else begin
                reqs         = (hold_reqs_p && v) ? dest_r : '0;
                release_flit = v & last_body;
            end
        end
    end

    assign protocol_err = err_r;

endmodule

// File: rtl/bsg_wormhole_router_input_control_vc.sv
// Multi-virtual-channel input controller for a wormhole router input port.
//
// Sits between the per-VC input FIFOs (already decoded) and the output-port
// arbiters. Every VC is controlled by its own independent channel instance;
// simultaneous dequeues on several VCs are legal.
//
// Ports (vectors are VC-major: VC n occupies slice n):
//   clk_i, reset_i        clock and synchronous active-high reset
//   fifo_v_i              per-VC head-flit valid
//   fifo_decoded_dest_i   per-VC one-hot destination (headers only)
//   fifo_payload_len_i    per-VC payload length (headers only)
//   fifo_yumi_i           per-VC dequeue of the head flit
//   reqs_o                per-VC output request
//   detected_header_o     per-VC head flit is a valid header
//   release_o             per-VC head flit is the last flit of its packet
//   busy_o                per-VC inside a packet body
//   protocol_err_o        per-VC sticky protocol-error flag

module bsg_wormhole_router_input_control_vc
    import bsg_wormhole_router_input_control_vc_pkg::*;
#(
    parameter int num_vc_p           = num_vc_lp,
    parameter int output_dirs_p      = output_dirs_lp,
    parameter int payload_len_bits_p = payload_len_bits_lp,
    parameter int hold_reqs_p        = hold_reqs_lp
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [num_vc_p-1:0]                    fifo_v_i,
    input  logic [num_vc_p*output_dirs_p-1:0]      fifo_decoded_dest_i,
    input  logic [num_vc_p*payload_len_bits_p-1:0] fifo_payload_len_i,
    input  logic [num_vc_p-1:0]                    fifo_yumi_i,
    output logic [num_vc_p*output_dirs_p-1:0]      reqs_o,
    output logic [num_vc_p-1:0]                    detected_header_o,
    output logic [num_vc_p-1:0]                    release_o,
    output logic [num_vc_p-1:0]                    busy_o,
    output logic [num_vc_p-1:0]                    protocol_err_o
);

    for (genvar vc = 0; vc < num_vc_p; vc++) begin : g_vc
        bsg_wormhole_router_input_control_vc_chan #(
            .dirs_p      (output_dirs_p),
            .len_bits_p  (payload_len_bits_p),
            .hold_reqs_p (hold_reqs_p != 0)
        ) chan (
            .clk             (clk_i),
            .reset           (reset_i),
            .v               (fifo_v_i[vc]),
            .dest            (fifo_decoded_dest_i[vc*output_dirs_p +: output_dirs_p]),
            .len             (fifo_payload_len_i[vc*payload_len_bits_p +: payload_len_bits_p]),
            .yumi            (fifo_yumi_i[vc]),
            .reqs            (reqs_o[vc*output_dirs_p +: output_dirs_p]),
            .detected_header (detected_header_o[vc]),
            .release_flit    (release_o[vc]),
            .busy            (busy_o[vc]),
            .protocol_err    (protocol_err_o[vc])
        );
    end

endmodule

// File: tb/tb_bsg_wormhole_router_input_control_vc.sv
module tb_bsg_wormhole_router_input_control_vc;
    import bsg_wormhole_router_input_control_vc_pkg::*;

    localparam int NV = 2;
    localparam int ND = 5;
    localparam int NL = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NV-1:0]     fifo_v;
    logic [NV*ND-1:0]  dest;
    logic [NV*NL-1:0]  len;
    logic [NV-1:0]     yumi;

    logic [NV*ND-1:0]  reqs_a, reqs_b;
    logic [NV-1:0]     hdr_a, hdr_b, rel_a, rel_b, busy_a, busy_b, err_a, err_b;

    always #5 clk = ~clk;

    // Holding variant (default) and non-holding variant share all inputs.
    bsg_wormhole_router_input_control_vc #(
        .num_vc_p(NV), .output_dirs_p(ND), .payload_len_bits_p(NL), .hold_reqs_p(1)
    ) dut (
        .clk_i(clk), .reset_i(reset), .fifo_v_i(fifo_v),
        .fifo_decoded_dest_i(dest), .fifo_payload_len_i(len), .fifo_yumi_i(yumi),
        .reqs_o(reqs_a), .detected_header_o(hdr_a), .release_o(rel_a),
        .busy_o(busy_a), .protocol_err_o(err_a)
    );

    bsg_wormhole_router_input_control_vc #(
        .num_vc_p(NV), .output_dirs_p(ND), .payload_len_bits_p(NL), .hold_reqs_p(0)
    ) dut_nh (
        .clk_i(clk), .reset_i(reset), .fifo_v_i(fifo_v),
        .fifo_decoded_dest_i(dest), .fifo_payload_len_i(len), .fifo_yumi_i(yumi),
        .reqs_o(reqs_b), .detected_header_o(hdr_b), .release_o(rel_b),
        .busy_o(busy_b), .protocol_err_o(err_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int vc, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s vc%0d actual=%0h required=%0h t=%0t", name, vc, act, exp, $time);
    endtask

    // Packet-level reference: flits still owed by the current packet,
    // the destination of that packet, and whether a protocol error was seen.
    int              flits_left [NV];
    logic [ND-1:0]   pkt_dest   [NV];
    bit              seen_err   [NV];

    initial begin
        for (int i = 0; i < NV; i++) begin
            flits_left[i] = 0;
            pkt_dest[i]   = '0;
            seen_err[i]   = 1'b0;
        end
    end

    task automatic model_check();
        for (int vc = 0; vc < NV; vc++) begin
            logic [ND-1:0] d;
            logic [NL-1:0] l;
            bit            in_pkt;
            d      = dest[vc*ND +: ND];
            l      = len[vc*NL +: NL];
            in_pkt = (flits_left[vc] != 0);
            for (int h = 0; h < 2; h++) begin
                logic [ND-1:0] e_reqs;
                bit e_hdr, e_rel, e_busy;
                e_reqs = '0; e_hdr = 0; e_rel = 0; e_busy = 0;
                if (!reset) begin
                    e_busy = in_pkt;
                    if (!in_pkt) begin
                        e_hdr = fifo_v[vc];
                        e_rel = fifo_v[vc] && (l == 0);
                        if (fifo_v[vc]) e_reqs = d;
                    end else begin
                        e_rel = fifo_v[vc] && (flits_left[vc] == 1);
                        if (fifo_v[vc] && h == 0) e_reqs = pkt_dest[vc];
                    end
                end
                if (h == 0) begin
                    chk("m_reqs_hold", vc, 32'(reqs_a[vc*ND +: ND]), 32'(e_reqs));
                    chk("m_hdr_hold",  vc, 32'(hdr_a[vc]),  32'(e_hdr));
                    chk("m_rel_hold",  vc, 32'(rel_a[vc]),  32'(e_rel));
                    chk("m_busy_hold", vc, 32'(busy_a[vc]), 32'(e_busy));
                    chk("m_err_hold",  vc, 32'(err_a[vc]),  32'(seen_err[vc]));
                end else begin
                    chk("m_reqs_nh", vc, 32'(reqs_b[vc*ND +: ND]), 32'(e_reqs));
                    chk("m_hdr_nh",  vc, 32'(hdr_b[vc]),  32'(e_hdr));
                    chk("m_rel_nh",  vc, 32'(rel_b[vc]),  32'(e_rel));
                    chk("m_busy_nh", vc, 32'(busy_b[vc]), 32'(e_busy));
                    chk("m_err_nh",  vc, 32'(err_b[vc]),  32'(seen_err[vc]));
                end
            end
        end
    endtask

    // State as it will be after the coming clock edge.
    task automatic model_update();
        for (int vc = 0; vc < NV; vc++) begin
            if (reset) begin
                flits_left[vc] = 0;
                pkt_dest[vc]   = '0;
                seen_err[vc]   = 1'b0;
            end else if (yumi[vc]) begin
                if (!fifo_v[vc]) begin
                    seen_err[vc] = 1'b1;
                end else if (flits_left[vc] == 0) begin
                    if ($countones(dest[vc*ND +: ND]) != 1) seen_err[vc] = 1'b1;
                    flits_left[vc] = int'(len[vc*NL +: NL]);
                    pkt_dest[vc]   = dest[vc*ND +: ND];
                end else begin
                    flits_left[vc] = flits_left[vc] - 1;
                end
            end
        end
    endtask

    // Drive one cycle's inputs after the falling edge, check the
    // combinational outputs, then advance the model for the rising edge.
    task automatic step(input bit rst, input logic [NV-1:0] v, input logic [NV*ND-1:0] d,
                        input logic [NV*NL-1:0] l, input logic [NV-1:0] y);
        @(negedge clk);
        reset  = rst;
        fifo_v = v;
        dest   = d;
        len    = l;
        yumi   = y;
        #1;
        model_check();
        model_update();
    endtask

    typedef struct {
        bit          rst;
        bit          v;
        logic [4:0]  d;
        logic [3:0]  l;
        bit          y;
        logic [4:0]  e_reqs;
        bit          e_hdr;
        bit          e_rel;
        bit          e_busy;
        bit          e_err;
    } vec_t;

    function automatic vec_t mk(bit rst, bit v, logic [4:0] d, logic [3:0] l, bit y,
                                logic [4:0] er, bit eh, bit erl, bit eb, bit ee);
        vec_t r;
        r.rst = rst; r.v = v; r.d = d; r.l = l; r.y = y;
        r.e_reqs = er; r.e_hdr = eh; r.e_rel = erl; r.e_busy = eb; r.e_err = ee;
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[$];

        reset  = 1'b1;
        fifo_v = '0;
        dest   = '0;
        len    = '0;
        yumi   = '0;

        // VC0 only, holding variant; VC1 idle.
        //              rst v  dest      len  y  reqs      hdr rel busy err
        tbl.push_back(mk(1, 1, 5'b01000, 3,   0, 5'b00000, 0,  0,  0,   0));
        tbl.push_back(mk(0, 1, 5'b00100, 0,   1, 5'b00100, 1,  1,  0,   0));
        tbl.push_back(mk(0, 0, 5'b00000, 0,   0, 5'b00000, 0,  0,  0,   0));
        tbl.push_back(mk(0, 1, 5'b01000, 3,   1, 5'b01000, 1,  0,  0,   0));
        tbl.push_back(mk(0, 1, 5'b00001, 0,   1, 5'b01000, 0,  0,  1,   0));
        tbl.push_back(mk(0, 1, 5'b00001, 0,   1, 5'b01000, 0,  0,  1,   0));
        tbl.push_back(mk(0, 0, 5'b00000, 0,   0, 5'b00000, 0,  0,  1,   0));
        tbl.push_back(mk(0, 0, 5'b00000, 0,   0, 5'b00000, 0,  0,  1,   0));
        tbl.push_back(mk(0, 1, 5'b00001, 0,   1, 5'b01000, 0,  1,  1,   0));
        tbl.push_back(mk(0, 1, 5'b00010, 1,   0, 5'b00010, 1,  0,  0,   0));
        tbl.push_back(mk(0, 1, 5'b00010, 1,   1, 5'b00010, 1,  0,  0,   0));
        tbl.push_back(mk(0, 1, 5'b10000, 0,   0, 5'b00010, 0,  1,  1,   0));
        tbl.push_back(mk(0, 1, 5'b10000, 0,   1, 5'b00010, 0,  1,  1,   0));
        tbl.push_back(mk(0, 0, 5'b00000, 0,   0, 5'b00000, 0,  0,  0,   0));

        foreach (tbl[i]) begin
            step(tbl[i].rst, {1'b0, tbl[i].v}, {5'b0, tbl[i].d}, {4'b0, tbl[i].l}, {1'b0, tbl[i].y});
            chk("tbl_reqs", 0, 32'(reqs_a[4:0]), 32'(tbl[i].e_reqs));
            chk("tbl_hdr",  0, 32'(hdr_a[0]),    32'(tbl[i].e_hdr));
            chk("tbl_rel",  0, 32'(rel_a[0]),    32'(tbl[i].e_rel));
            chk("tbl_busy", 0, 32'(busy_a[0]),   32'(tbl[i].e_busy));
            chk("tbl_err",  0, 32'(err_a[0]),    32'(tbl[i].e_err));
        end

        // Interleaved VC0 len=2 and VC1 len=1 with simultaneous dequeues.
        step(0, 2'b11, {5'b00001, 5'b00010}, {4'd1, 4'd2}, 2'b11);
        chk("ilv_hdr", 0, 32'(hdr_a), 32'(2'b11));
        step(0, 2'b11, {5'b10000, 5'b10000}, '0, 2'b11);
        chk("ilv_rel1", 0, 32'(rel_a), 32'(2'b10));
        chk("ilv_reqs", 0, 32'(reqs_a), 32'({5'b00001, 5'b00010}));
        step(0, 2'b01, '0, '0, 2'b01);
        chk("ilv_rel2", 0, 32'(rel_a), 32'(2'b01));
        chk("ilv_busy", 0, 32'(busy_a), 32'(2'b01));
        step(0, 2'b00, '0, '0, 2'b00);
        chk("ilv_idle", 0, 32'(busy_a), 32'(2'b00));

        // Invalid yumi mid-packet: flag sets, counter untouched.
        step(0, 2'b01, {5'b0, 5'b00100}, {4'd0, 4'd3}, 2'b01);
        step(0, 2'b00, '0, '0, 2'b01);
        chk("err_not_yet", 0, 32'(err_a[0]), 32'(0));
        step(0, 2'b01, '0, '0, 2'b00);
        chk("err_yumi", 0, 32'(err_a[0]), 32'(1));
        chk("err_busy", 0, 32'(busy_a[0]), 32'(1));
        step(0, 2'b01, '0, '0, 2'b01);
        chk("err_ctr3", 0, 32'(rel_a[0]), 32'(0));
        step(0, 2'b01, '0, '0, 2'b01);
        chk("err_ctr2", 0, 32'(rel_a[0]), 32'(0));
        step(0, 2'b01, '0, '0, 2'b01);
        chk("err_ctr1", 0, 32'(rel_a[0]), 32'(1));
        // Non-one-hot header on VC1.
        step(0, 2'b10, {5'b00110, 5'b0}, '0, 2'b10);
        step(0, 2'b00, '0, '0, 2'b00);
        chk("err_dest", 1, 32'(err_a), 32'(2'b11));
        step(0, 2'b00, '0, '0, 2'b00);
        chk("err_sticky", 1, 32'(err_a), 32'(2'b11));
        step(1, 2'b00, '0, '0, 2'b00);
        step(0, 2'b00, '0, '0, 2'b00);
        chk("err_cleared", 0, 32'(err_a), 32'(2'b00));

        // Maximum length, reset mid-packet.
        step(0, 2'b01, {5'b0, 5'b00001}, {4'd0, 4'd15}, 2'b01);
        for (int i = 0; i < 5; i++) step(0, 2'b01, '0, '0, 2'b01);
        chk("max_busy", 0, 32'(busy_a[0]), 32'(1));
        step(1, 2'b01, {5'b0, 5'b00010}, {4'd0, 4'd2}, 2'b00);
        chk("rst_reqs", 0, 32'(reqs_a), 32'(0));
        chk("rst_hdr",  0, 32'(hdr_a),  32'(0));
        chk("rst_rel",  0, 32'(rel_a),  32'(0));
        chk("rst_busy", 0, 32'(busy_a), 32'(0));
        step(0, 2'b01, {5'b0, 5'b00010}, {4'd0, 4'd2}, 2'b00);
        chk("post_rst_hdr",  0, 32'(hdr_a[0]),  32'(1));
        chk("post_rst_busy", 0, 32'(busy_a[0]), 32'(0));

        // Randomized traffic against the reference.
        for (int n = 0; n < 500; n++) begin
            logic [NV-1:0]    rv, ry;
            logic [NV*ND-1:0] rd;
            logic [NV*NL-1:0] rl;
            bit               rr;
            rr = ($urandom_range(99) == 0);
            rv = NV'($urandom);
            for (int vc = 0; vc < NV; vc++) begin
                ry[vc] = rv[vc] ? 1'($urandom) : ($urandom_range(49) == 0);
                rd[vc*ND +: ND] = ($urandom_range(19) == 0) ? ND'($urandom)
                                                             : ND'(1 << $urandom_range(ND-1));
                rl[vc*NL +: NL] = ($urandom_range(3) == 0) ? '0 : NL'($urandom_range(15));
            end
            step(rr, rv, rd, rl, ry);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bsg_wormhole_router_input_control_vc.md
Name: bsg_wormhole_router_input_control_vc

Overview:
- Multi-virtual-channel input controller for a wormhole router input port.
- Each VC has its own payload counter that tracks the head flit of that VC's input FIFO.
- Raises output-direction requests on headers, optionally holds them for the packet body, and flags the last flit of each packet.
- Sits between the per-VC input FIFOs (decode already done) and the output-port arbiters.

Parameters:
- num_vc_p, 2, number of virtual channels, each controlled independently.
- output_dirs_p, 5, number of output directions (request vector width).
- payload_len_bits_p, 4, width of the header payload-length field (body flits after the header).
- hold_reqs_p, 1, 1 = reqs_o repeats the latched destination for every body flit; 0 = reqs_o only on headers.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- fifo_v_i  in  num_vc_p  per-VC head-flit valid.
- fifo_decoded_dest_i  in  num_vc_p*output_dirs_p  per-VC one-hot destination, meaningful on headers only.
- fifo_payload_len_i  in  num_vc_p*payload_len_bits_p  per-VC payload length, meaningful on headers only.
- fifo_yumi_i  in  num_vc_p  per-VC dequeue of the head flit.
- reqs_o  out  num_vc_p*output_dirs_p  per-VC output request.
- detected_header_o  out  num_vc_p  head flit is a valid header.
- release_o  out  num_vc_p  head flit is valid and is the last flit of its packet.
- busy_o  out  num_vc_p  VC is inside a packet body.
- protocol_err_o  out  num_vc_p  sticky protocol-error flag.

Behaviour:
- Clock and reset: one clock (clk_i). Reset_i is synchronous and active-high.
- Per-VC registers: ctr_r (payload_len_bits_p bits), dest_r (output_dirs_p bits), err_r (1 bit). Reset sets all to 0, so every VC starts in IDLE.
- State is derived, not separately stored: IDLE when ctr_r==0, BODY when ctr_r!=0. busy_o = (ctr_r!=0).
- Outputs are combinational from registers and inputs; there is no internal latency.
- During reset (reset_i=1) all outputs are driven 0 except protocol_err_o, which shows err_r. At reset, reqs_o, detected_header_o, release_o and busy_o are all 0.
- IDLE:
  - detected_header_o = fifo_v_i.
  - reqs_o = fifo_v_i ? fifo_decoded_dest_i : 0.
  - release_o = fifo_v_i & (fifo_payload_len_i==0).
  - On yumi: ctr_r <= fifo_payload_len_i and dest_r <= fifo_decoded_dest_i. A zero-length packet therefore stays in IDLE.
- BODY:
  - detected_header_o = 0.
  - reqs_o = (hold_reqs_p & fifo_v_i) ? dest_r : 0.
  - release_o = fifo_v_i & (ctr_r==1).
  - On yumi: ctr_r <= ctr_r-1. Reaching 0 returns the VC to IDLE, and the next flit is treated as a header.
- No yumi: all state holds, including while fifo_v_i=0 mid-packet (bubbles are allowed).
- Maximum length 2^payload_len_bits_p-1 loads without truncation. The counter never wraps, because decrement only happens while ctr_r!=0.
- VCs are fully independent. Simultaneous yumi on several VCs in the same cycle is legal.
- protocol_err_o sets (sticky until reset) on either condition:
  - fifo_yumi_i while fifo_v_i=0; the counter still does not change.
  - Header yumi with fifo_decoded_dest_i not one-hot.
- Reset mid-packet: ctr_r is cleared, so the next valid flit is treated as a header. The upstream FIFOs are reset together with this block.

Decomposition:
- Shared package holds:
  - typedef bsg_wormhole_len_t (payload_len_bits_p-wide length).
  - constants for the VC and direction index widths.
- One natural sub-module, bsg_wormhole_router_input_control_vc_chan: holds one VC's counter, dest latch and error flag, and is instantiated num_vc_p times with a generate loop.
- The counter inside it is a set/down counter with load priority over decrement.

Test Plan:
- VC0 header, len=0, dest=5'b00100, v=1: detected_header_o[0]=1, release_o[0]=1, reqs_o[0]=00100. After yumi, busy_o[0]=0.
- VC0 header, len=3, dest=5'b01000, yumi every cycle: release_o[0] pattern 0,0,0,1. With hold_reqs_p=1, reqs_o[0]=01000 for all 4 flits; with hold_reqs_p=0, reqs_o[0]=01000 on the header only. Next flit: detected_header_o[0]=1.
- Same len=3 packet with fifo_v_i dropping for 2 cycles after flit 2: busy_o[0] holds 1, ctr_r holds 2, reqs_o[0]=0 while v=0, and the packet completes correctly afterwards.
- VC0 len=2 and VC1 len=1 interleaved, with yumi on both in the same cycle: each release_o fires on its own last flit with no cross-talk.
- Yumi with v=0, and a header with dest=5'b00110: protocol_err_o sets and stays 1 until reset_i; ctr_r is unchanged by the invalid yumi.
- Len=15 (max for 4 bits), then reset_i asserted after 5 body flits: all outputs 0 during reset. Afterwards the next valid flit gives detected_header_o=1.
